// File: rtl/dl_code_sequencer.sv
// Applies a 10-bit DLL delay code: walks the coarse thermometer one cell per step with
// settling gaps, then slews the fine code, and pulses lock_done when the target is reached.
module dl_code_sequencer #(
    parameter logic [9:0]  RST_CODE      = 10'd512,
    parameter int unsigned STEP_WAIT     = 1,
    parameter int unsigned FINE_MAX_STEP = 63
) (
    input  logic        clk_ext,
    input  logic        rst_n,
    input  logic        code_valid,
    input  logic [9:0]  code_in,
    output logic        code_ready,
    output logic [15:0] T,
    output logic [15:0] Tb,
    output logic [5:0]  fine,
    output logic [9:0]  code_cur,
    output logic        busy,
    output logic        lock_done
);

    typedef enum logic [2:0] {StIdle, StCoarse, StWait, StFine, StDone} state_e;

    localparam logic [3:0] StepWait = 4'(STEP_WAIT);
    localparam logic [6:0] FineMax  = 7'(FINE_MAX_STEP);

    state_e     state_q, state_d;
    logic [3:0] coarse_q, coarse_d;
    logic [5:0] fine_q, fine_d;
    logic [9:0] tgt_q, tgt_d;
    logic [3:0] cnt_q, cnt_d;

    logic [3:0] coarse_nxt;
    logic [6:0] fine_w, tgt_fw, fine_gap, fine_inc, fine_nxt;

    // Where to go once the coarse index has settled at value c.
    function automatic state_e exit_state(input logic [3:0] c, input logic [5:0] f,
                                          input logic [9:0] t);
        if (c != t[9:6]) return StCoarse;
        if (f != t[5:0]) return StFine;
        return StDone;
    endfunction

    always_ff @(posedge clk_ext) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            coarse_q <= RST_CODE[9:6];
            fine_q   <= RST_CODE[5:0];
            tgt_q    <= RST_CODE;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            coarse_q <= coarse_d;
            fine_q   <= fine_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        coarse_d = coarse_q;
        fine_d   = fine_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;

        coarse_nxt = (tgt_q[9:6] > coarse_q) ? coarse_q + 4'd1 : coarse_q - 4'd1;

        // Fine slew in 7 bits so the step never wraps past 0 or 63.
        fine_w   = {1'b0, fine_q};
        tgt_fw   = {1'b0, tgt_q[5:0]};
        fine_gap = (tgt_fw >= fine_w) ? tgt_fw - fine_w : fine_w - tgt_fw;
        fine_inc = (fine_gap < FineMax) ? fine_gap : FineMax;
        fine_nxt = (tgt_fw >= fine_w) ? fine_w + fine_inc : fine_w - fine_inc;

        unique case (state_q)
            StIdle: begin
                if (code_valid) begin
                    tgt_d   = code_in;
                    state_d = exit_state(coarse_q, fine_q, code_in);
                end
            end
            StCoarse: begin
                if (coarse_q != tgt_q[9:6]) begin
                    coarse_d = coarse_nxt;
                    if (STEP_WAIT != 0) begin
                        state_d = StWait;
                        cnt_d   = StepWait;
                    end else begin
                        state_d = exit_state(coarse_nxt, fine_q, tgt_q);
                    end
                end else begin
                    state_d = exit_state(coarse_q, fine_q, tgt_q);
                end
            end
            StWait: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = exit_state(coarse_q, fine_q, tgt_q);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StFine: begin
                fine_d = fine_nxt[5:0];
                if (fine_nxt == tgt_fw) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            T[i] = (4'(i) <= coarse_q);
        end
        Tb         = ~T;
        fine       = fine_q;
        code_cur   = {coarse_q, fine_q};
        code_ready = (state_q == StIdle);
        busy       = (state_q != StIdle);
        lock_done  = (state_q == StDone);
    end

endmodule

// File: tb/tb_dl_code_sequencer.sv
// Bench for dl_code_sequencer: directed corner sequences, a latency/result table, and random
// targets checked against a latency/result model derived from the code distances.
module tb_dl_code_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic [9:0]  a_code, b_code;
    logic        a_ready, b_ready, a_busy, b_busy, a_lock, b_lock;
    logic [15:0] a_T, a_Tb, b_T, b_Tb;
    logic [5:0]  a_fine, b_fine;
    logic [9:0]  a_cur, b_cur;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Default parameters.
    dl_code_sequencer dut_a (
        .clk_ext(clk), .rst_n(rst_n), .code_valid(a_valid), .code_in(a_code),
        .code_ready(a_ready), .T(a_T), .Tb(a_Tb), .fine(a_fine), .code_cur(a_cur),
        .busy(a_busy), .lock_done(a_lock)
    );

    // No settling gap, limited fine slew.
    dl_code_sequencer #(.RST_CODE(10'd512), .STEP_WAIT(0), .FINE_MAX_STEP(16)) dut_b (
        .clk_ext(clk), .rst_n(rst_n), .code_valid(b_valid), .code_in(b_code),
        .code_ready(b_ready), .T(b_T), .Tb(b_Tb), .fine(b_fine), .code_cur(b_cur),
        .busy(b_busy), .lock_done(b_lock)
    );

    typedef struct {
        logic [9:0] code;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] therm(input logic [3:0] c);
        logic [15:0] t;
        for (int i = 0; i < 16; i++) t[i] = (i <= int'(c));
        return t;
    endfunction

    // Edges after the accept edge until DONE is entered.
    function automatic int model_lat(input logic [9:0] from, input logic [9:0] to,
                                     input int sw, input int fms);
        int d, f;
        d = int'(from[9:6]) - int'(to[9:6]);
        f = int'(from[5:0]) - int'(to[5:0]);
        if (d < 0) d = -d;
        if (f < 0) f = -f;
        return d * (1 + sw) + (f + fms - 1) / fms;
    endfunction

    function automatic logic get_lock(input bit sel);
        return sel ? b_lock : a_lock;
    endfunction

    // Issue one transfer and count edges until lock_done is seen (-1 on timeout).
    task automatic xfer(input bit sel, input logic [9:0] code, output int lat);
        lat = -1;
        if (sel) begin b_valid = 1'b1; b_code = code; end
        else     begin a_valid = 1'b1; a_code = code; end
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (get_lock(sel)) lat = 0;
        for (int k = 1; k <= 200 && lat < 0; k++) begin
            step();
            if (get_lock(sel)) lat = k;
        end
    endtask

    // Per-cycle invariants: T/Tb decode, ready/busy, single-cell coarse moves.
    logic        mon_en = 1'b0;
    logic        primed = 1'b0;
    logic        rst_e;
    logic [15:0] prev_a, prev_b;
    always @(posedge clk) begin
        rst_e = rst_n;
        #1;
        if (mon_en) begin
            chk("mon_a", {31'd0, (a_T == therm(a_cur[9:6])) && (a_Tb == ~a_T) &&
                (a_ready == !a_busy) && (a_fine == a_cur[5:0]) &&
                (!primed || !rst_e || $countones(a_T ^ prev_a) <= 1)}, 32'd1);
            chk("mon_b", {31'd0, (b_T == therm(b_cur[9:6])) && (b_Tb == ~b_T) &&
                (b_ready == !b_busy) && (b_fine == b_cur[5:0]) &&
                (!primed || !rst_e || $countones(b_T ^ prev_b) <= 1)}, 32'd1);
        end
        prev_a = a_T;
        prev_b = b_T;
        primed = mon_en;
    end

    initial begin
        vec_t       tbl[6];
        int         fexp[4];
        int         lat, moves;
        logic       seen;
        logic [3:0] last_c;
        logic [9:0] code, model_a, model_b;

        tbl[0] = '{10'd650, 5};
        tbl[1] = '{10'd650, 0};
        tbl[2] = '{10'd0, 21};
        tbl[3] = '{10'd1023, 31};
        tbl[4] = '{10'd512, 15};
        tbl[5] = '{10'd575, 1};
        fexp   = '{16, 32, 48, 63};

        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_code = '0; b_code = '0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_T", a_T, 32'h01FF);
        chk("rst_Tb", a_Tb, 32'hFE00);
        chk("rst_fine", a_fine, 0);
        chk("rst_cur", a_cur, 512);
        chk("rst_ready", a_ready, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_lock", a_lock, 0);
        chk("rst_b_cur", b_cur, 512);
        mon_en = 1'b1;

        // 650 from reset with one settling cycle per step.
        a_valid = 1'b1; a_code = 10'd650;
        step();
        a_valid = 1'b0;
        chk("s650_e0_busy", a_busy, 1);
        step(); chk("s650_e1_coarse", a_cur[9:6], 9);
        step(); chk("s650_e2_coarse", a_cur[9:6], 9);
        step(); chk("s650_e3_T", a_T, 32'h07FF);
        step(); chk("s650_e4_cur", a_cur, 640); chk("s650_e4_lock", a_lock, 0);
        step(); chk("s650_e5_fine", a_fine, 10); chk("s650_e5_lock", a_lock, 1);
        step(); chk("s650_e6_ready", a_ready, 1); chk("s650_e6_lock", a_lock, 0);

        // Fine-only slew limited to 16 per edge.
        b_valid = 1'b1; b_code = 10'd575;
        step();
        b_valid = 1'b0;
        chk("s575_e0_busy", b_busy, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("s575_fine", b_fine, fexp[k]);
            chk("s575_coarse", b_cur[9:6], 8);
            chk("s575_lock", b_lock, (k == 3) ? 1 : 0);
        end
        step(); chk("s575_ready", b_ready, 1); chk("s575_lock_end", b_lock, 0);

        // Null transfer: DONE on the accept edge.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        a_valid = 1'b1; a_code = 10'd512;
        step();
        a_valid = 1'b0;
        chk("null_lock", a_lock, 1);
        chk("null_T", a_T, 32'h01FF);
        chk("null_fine", a_fine, 0);
        step(); chk("null_lock_end", a_lock, 0); chk("null_ready", a_ready, 1);

        // Table of sequential transfers on the default instance.
        foreach (tbl[i]) begin
            xfer(1'b0, tbl[i].code, lat);
            chk("tbl_lat", lat, tbl[i].lat);
            chk("tbl_cur", a_cur, {22'd0, tbl[i].code});
            step();
        end

        // Full-range walk with ignored requests while busy.
        xfer(1'b0, 10'd1023, lat);
        chk("walk_pre_lat", lat, 14);
        step();
        a_valid = 1'b1; a_code = 10'd0;
        step();
        a_code = 10'd300;
        lat = -1; moves = 0; seen = 1'b0; last_c = a_cur[9:6];
        for (int k = 1; k <= 200 && lat < 0; k++) begin
            if (a_ready) seen = 1'b1;
            step();
            if (a_cur[9:6] != last_c) moves++;
            last_c = a_cur[9:6];
            if (a_lock) begin lat = k; a_valid = 1'b0; end
        end
        a_valid = 1'b0;
        chk("walk_lat", lat, 31);
        chk("walk_moves", moves, 15);
        chk("walk_ready_low", seen, 0);
        chk("walk_cur", a_cur, 0);
        step();
        repeat (2) step();
        chk("walk_ignored", a_cur, 0);

        // Reset while in WAIT.
        a_valid = 1'b1; a_code = 10'd650;
        step();
        a_valid = 1'b0;
        step();
        chk("rw_coarse", a_cur[9:6], 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rw_T", a_T, 32'h01FF);
        chk("rw_cur", a_cur, 512);
        chk("rw_ready", a_ready, 1);
        seen = a_lock;
        repeat (5) begin step(); seen = seen | a_lock | a_busy; end
        chk("rw_no_lock", seen, 0);
        chk("rw_cur_hold", a_cur, 512);

        // Transfer on a reset edge is dropped.
        rst_n = 1'b0; a_valid = 1'b1; a_code = 10'd100;
        step();
        a_valid = 1'b0; rst_n = 1'b1;
        seen = 1'b0;
        repeat (3) begin step(); seen = seen | a_busy; end
        chk("rstx_busy", seen, 0);
        chk("rstx_cur", a_cur, 512);

        // Random targets against the distance model.
        model_a = 10'd512;
        model_b = 10'd512;
        for (int n = 0; n < 25; n++) begin
            code = 10'($urandom_range(0, 1023));
            xfer(1'b1, code, lat);
            chk("rnd_b_lat", lat, model_lat(model_b, code, 0, 16));
            chk("rnd_b_cur", b_cur, {22'd0, code});
            model_b = code;
            step();
            code = 10'($urandom_range(0, 1023));
            xfer(1'b0, code, lat);
            chk("rnd_a_lat", lat, model_lat(model_a, code, 1, 63));
            chk("rnd_a_cur", a_cur, {22'd0, code});
            model_a = code;
            step();
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
